// File: rtl/rstseq_pkg.sv
// Shared types for the SoC reset sequencer. The CSR/uncore side imports this
// package as well so it can decode ResetCause.
package rstseq_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rstseq_state_t;

    typedef enum logic [1:0] {
        EXT      = 2'd0,
        SW       = 2'd1,
        WDT      = 2'd2,
        LOCKLOSS = 2'd3
    } rstcause_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rstsequencer_syncn.sv
// N-stage flop chain used to bring an asynchronous level into the clk domain.
// Resets to 0 so a freshly reset sequencer never sees a stale "locked".
module syncn #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // shift the input through the chain, oldest sample at the top
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rstsequencer.sv
// SoC reset sequencer: holds NCH reset domains until PLL lock, releases them
// one at a time in index order, and re-sequences on software reset, watchdog
// expiry or lock loss while recording the cause.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// HOLD      | all channels held; nonzero hold_cnt = post-SW/WDT hold time
// WAIT_LOCK | all channels held until the synchronised PLL lock is seen
// RELEASE   | channels released one per STAGE_DELAY cycles, index order
// RUN       | all channels released; watching for reset triggers
module rstsequencer
    import rstseq_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DELAY = 16,
    parameter int SWRST_HOLD  = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           PLLlock,
    input  logic           SwResetReq,
    input  logic           WdtExpire,
    output logic [NCH-1:0] ResetOut,
    output logic           ResetDone,
    output logic [1:0]     ResetCause,
    output logic [1:0]     State
);

    localparam int CW = $clog2(max_int(STAGE_DELAY, SWRST_HOLD) + 1);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CW-1:0] REL_LAST  = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(SWRST_HOLD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);

    rstseq_state_t state;
    rstcause_t     cause;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] rel_cnt;
    logic [IW-1:0] idx;
    logic          lock_sync;

    syncn #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .reset(reset),
        .d    (PLLlock),
        .q    (lock_sync)
    );

    // sequencing FSM with its counters, channel index and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HOLD;
            cause     <= EXT;
            hold_cnt  <= '0;
            rel_cnt   <= '0;
            idx       <= '0;
            ResetOut  <= '1;
            ResetDone <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end else begin
                        state <= WAIT_LOCK;
                    end
                end

                WAIT_LOCK: begin
                    if (lock_sync) begin
                        state   <= RELEASE;
                        rel_cnt <= '0;
                        idx     <= '0;
                    end
                end

                RELEASE: begin
                    if (!lock_sync) begin
                        ResetOut <= '1;
                        cause    <= LOCKLOSS;
                        state    <= WAIT_LOCK;
                    end else if (rel_cnt == REL_LAST) begin
                        ResetOut[idx] <= 1'b0;
                        rel_cnt       <= '0;
                        idx           <= idx + IW'(1);
                        if (idx == IDX_LAST) begin
                            state     <= RUN;
                            ResetDone <= 1'b1;
                        end
                    end else begin
                        rel_cnt <= rel_cnt + CW'(1);
                    end
                end

                RUN: begin
                    // lock loss outranks watchdog, which outranks software
                    if (!lock_sync) begin
                        ResetOut  <= '1;
                        ResetDone <= 1'b0;
                        cause     <= LOCKLOSS;
                        state     <= WAIT_LOCK;
                    end else if (WdtExpire) begin
                        ResetOut  <= '1;
                        ResetDone <= 1'b0;
                        cause     <= WDT;
                        hold_cnt  <= HOLD_LOAD;
                        state     <= HOLD;
                    end else if (SwResetReq) begin
                        ResetOut  <= '1;
                        ResetDone <= 1'b0;
                        cause     <= SW;
                        hold_cnt  <= HOLD_LOAD;
                        state     <= HOLD;
                    end
                end

                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

    assign State      = state;
    assign ResetCause = cause;

endmodule
